// File: rtl/fpu_addsub_arbiter.sv
// rtl/fpu_addsub_arbiter.sv - round-robin arbiter sharing one add/sub unit among NREQ requesters
module fpu_addsub_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      oper_in,
    input  logic [32*NREQ-1:0]   a_in,
    input  logic [32*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          result,
    output logic                 err,
    output logic                 busy,
    output logic                 fu_start,
    output logic                 fu_oper,
    output logic [31:0]          fu_a,
    output logic [31:0]          fu_b,
    input  logic [31:0]          fu_r,
    input  logic                 fu_ready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_DRAIN} state_t;

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   last;
    logic [IW-1:0]   gnt;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   pick;
    logic            pick_valid;
    logic [CW-1:0]   cnt;
    logic            timeout_hit;

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    // Round-robin search: first requester after the last winner, wrapping at NREQ
    always_comb begin
        cand       = last;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == IW'(NREQ - 1)) ? '0 : cand + IW'(1);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    // Next-state logic; ready takes precedence over the watchdog in BUSY
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pick_valid) state_next = S_BUSY;
            S_BUSY:  if (fu_ready || timeout_hit) state_next = S_DONE;
            S_DONE:  state_next = S_DRAIN;
            S_DRAIN: if (!fu_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered outputs, operand latches, pointer and watchdog counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= '0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            result   <= '0;
            fu_start <= 1'b0;
            fu_oper  <= 1'b0;
            fu_a     <= '0;
            fu_b     <= '0;
            last     <= IW'(NREQ - 1);
            gnt      <= '0;
            cnt      <= '0;
        end else begin
            ack  <= '0;
            done <= '0;
            err  <= 1'b0;
            busy <= (state_next != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        fu_oper  <= oper_in[pick];
                        fu_a     <= a_in[{pick, 5'b0} +: 32];
                        fu_b     <= b_in[{pick, 5'b0} +: 32];
                        last     <= pick;
                        gnt      <= pick;
                        ack      <= NREQ'(1) << pick;
                        fu_start <= 1'b1;
                        cnt      <= '0;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (fu_ready) begin
                        result   <= fu_r;
                        fu_start <= 1'b0;
                        done     <= NREQ'(1) << gnt;
                    end else if (timeout_hit) begin
                        result   <= QNAN;
                        err      <= 1'b1;
                        fu_start <= 1'b0;
                        done     <= NREQ'(1) << gnt;
                    end
                end
                S_DRAIN: begin
                    fu_start <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb/tb_fpu_addsub_arbiter.sv - directed self-checking bench for fpu_addsub_arbiter
module tb_fpu_addsub_arbiter;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    req = '0;
    logic [3:0]    oper_in = '0;
    logic [127:0]  a_in = '0;
    logic [127:0]  b_in = '0;
    logic [3:0]    ack;
    logic [3:0]    done;
    logic [31:0]   result;
    logic          err;
    logic          busy;
    logic          fu_start;
    logic          fu_oper;
    logic [31:0]   fu_a;
    logic [31:0]   fu_b;
    logic [31:0]   fu_r = '0;
    logic          fu_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int lat = 4;
    logic hang = 1'b0;
    int cyc = 0;

    fpu_addsub_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .req(req), .oper_in(oper_in),
        .a_in(a_in), .b_in(b_in), .ack(ack), .done(done), .result(result),
        .err(err), .busy(busy), .fu_start(fu_start), .fu_oper(fu_oper),
        .fu_a(fu_a), .fu_b(fu_b), .fu_r(fu_r), .fu_ready(fu_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fu_model(input logic op, input logic [31:0] a, input logic [31:0] b);
        if (!op && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
        if (!op && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
        if (!op && a == 32'h40800000 && b == 32'h40000000) return 32'h40C00000;
        if ( op && a == 32'h40800000 && b == 32'h40000000) return 32'h40000000;
        if ( op && a == 32'h40000000 && b == 32'h3F800000) return 32'h3F800000;
        return 32'hDEADBEEF;
    endfunction

    // Shared unit model: ready after lat cycles of start, held until start drops
    always @(posedge clk) begin
        if (!fu_start || hang) begin
            cyc      <= 0;
            fu_ready <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (cyc == lat - 1) begin
                fu_ready <= 1'b1;
                fu_r     <= fu_model(fu_oper, fu_a, fu_b);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
        oper_in[i]      = op;
        a_in[32*i +: 32] = a;
        b_in[32*i +: 32] = b;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == '0 && n < 300);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < 300);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 300);
        chk("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] exp_res [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h3F800000};

    initial begin
        int n;
        int stray;
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fu_start", {31'b0, fu_start}, 32'd0);
        chk("rst_ack_done", {24'b0, ack, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_fu_a", fu_a, 32'd0);
        reset = 1'b0;

        // single add on requester 0
        @(negedge clk);
        set_ops(0, 1'b0, 32'h40800000, 32'h40000000);
        req = 4'b0001;
        @(negedge clk);
        chk("add_ack", {28'b0, ack}, 32'h1);
        chk("add_fu_start", {31'b0, fu_start}, 32'd1);
        chk("add_fu_a", fu_a, 32'h40800000);
        chk("add_fu_b", fu_b, 32'h40000000);
        chk("add_busy", {31'b0, busy}, 32'd1);
        req = 4'b0000;
        wait_done(n);
        chk("add_latency", n, 32'd5);
        chk("add_done", {28'b0, done}, 32'h1);
        chk("add_result", result, 32'h40C00000);
        chk("add_err", {31'b0, err}, 32'd0);
        chk("add_fu_start_low", {31'b0, fu_start}, 32'd0);
        @(negedge clk);
        chk("add_done_pulse", {28'b0, done}, 32'h0);
        chk("add_drain_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        chk("add_idle_busy", {31'b0, busy}, 32'd0);

        // single sub on requester 1
        set_ops(1, 1'b1, 32'h40800000, 32'h40000000);
        req = 4'b0010;
        @(negedge clk);
        chk("sub_ack", {28'b0, ack}, 32'h2);
        chk("sub_fu_oper", {31'b0, fu_oper}, 32'd1);
        req = 4'b0000;
        @(negedge clk);
        chk("sub_fu_oper_hold", {31'b0, fu_oper}, 32'd1);
        chk("sub_fu_start_hold", {31'b0, fu_start}, 32'd1);
        wait_done(n);
        chk("sub_done", {28'b0, done}, 32'h2);
        chk("sub_result", result, 32'h40000000);
        wait_idle();

        // contention after reset: 0 then 2
        do_reset();
        set_ops(0, 1'b0, 32'h3F800000, 32'h3F800000);
        set_ops(2, 1'b0, 32'h40000000, 32'h40000000);
        req = 4'b0101;
        @(negedge clk);
        chk("cont_ack0", {28'b0, ack}, 32'h1);
        chk("cont_fu_a0", fu_a, 32'h3F800000);
        req = 4'b0100;
        wait_done(n);
        chk("cont_done0", {28'b0, done}, 32'h1);
        chk("cont_result0", result, 32'h40000000);
        wait_ack(n);
        chk("cont_gap", n, 32'd3);
        chk("cont_ack2", {28'b0, ack}, 32'h4);
        chk("cont_fu_a2", fu_a, 32'h40000000);
        chk("cont_fu_b2", fu_b, 32'h40000000);
        req = 4'b0000;
        wait_done(n);
        chk("cont_done2", {28'b0, done}, 32'h4);
        chk("cont_result2", result, 32'h40800000);
        wait_idle();

        // fairness: all requesters held high
        do_reset();
        set_ops(0, 1'b0, 32'h3F800000, 32'h3F800000);
        set_ops(1, 1'b0, 32'h40000000, 32'h40000000);
        set_ops(2, 1'b0, 32'h40800000, 32'h40000000);
        set_ops(3, 1'b1, 32'h40000000, 32'h3F800000);
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wait_ack(n);
            chk($sformatf("fair_ack%0d", k), {28'b0, ack}, 32'(1 << (k % 4)));
            wait_done(n);
            chk($sformatf("fair_done%0d", k), {28'b0, done}, 32'(1 << (k % 4)));
            chk($sformatf("fair_result%0d", k), result, exp_res[k % 4]);
        end
        req = 4'b0000;
        wait_idle();

        // watchdog timeout: unit never ready
        hang = 1'b1;
        set_ops(0, 1'b0, 32'h40800000, 32'h40000000);
        req = 4'b0001;
        @(negedge clk);
        chk("to_ack", {28'b0, ack}, 32'h1);
        req = 4'b0000;
        wait_done(n);
        chk("to_latency", n, 32'd64);
        chk("to_done", {28'b0, done}, 32'h1);
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_result", result, 32'h7FC00000);
        chk("to_fu_start", {31'b0, fu_start}, 32'd0);
        @(negedge clk);
        chk("to_err_pulse", {31'b0, err}, 32'd0);
        wait_idle();
        hang = 1'b0;

        // ready on the last watchdog cycle wins
        lat = 63;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        wait_done(n);
        chk("race_latency", n, 32'd64);
        chk("race_err", {31'b0, err}, 32'd0);
        chk("race_result", result, 32'h40C00000);
        wait_idle();
        lat = 4;

        // reset two cycles into BUSY, then req[3]
        set_ops(2, 1'b0, 32'h40800000, 32'h40000000);
        req = 4'b0100;
        @(negedge clk);
        chk("mid_ack", {28'b0, ack}, 32'h4);
        req = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_fu_start", {31'b0, fu_start}, 32'd0);
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_fu_a", fu_a, 32'd0);
        reset = 1'b0;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (done != '0) stray++;
        end
        chk("mid_no_done", stray, 32'd0);
        set_ops(3, 1'b1, 32'h40000000, 32'h3F800000);
        req = 4'b1000;
        @(negedge clk);
        chk("post_ack3", {28'b0, ack}, 32'h8);
        req = 4'b0000;
        wait_done(n);
        chk("post_done3", {28'b0, done}, 32'h8);
        chk("post_result3", result, 32'h3F800000);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
